// File: rtl/vga_rect_painter.sv
// Queued rectangle rasteriser feeding the vga_adapter write port, one pixel per clock.
// Requests are buffered in a small FIFO; each is drawn as a clipped BLOCK_W x BLOCK_H fill/outline/bordered block.
module vga_rect_painter #(
  parameter int unsigned          X_W          = 10,
  parameter int unsigned          Y_W          = 9,
  parameter int unsigned          COLOR_W      = 9,
  parameter int unsigned          BLOCK_W      = 30,
  parameter int unsigned          BLOCK_H      = 30,
  parameter int unsigned          SCREEN_W     = 640,
  parameter int unsigned          SCREEN_H     = 480,
  parameter int unsigned          FIFO_DEPTH   = 4,
  parameter logic [COLOR_W-1:0]   BORDER_COLOR = '0,
  localparam int unsigned         CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x,
  input  logic [Y_W-1:0]     req_y,
  input  logic [COLOR_W-1:0] req_color,
  input  logic [1:0]         req_mode,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_write,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   fifo_count
);

  localparam int unsigned      AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned      ENT_W  = X_W + Y_W + COLOR_W + 2;
  localparam logic [X_W-1:0]   LAST_X = X_W'(BLOCK_W - 1);
  localparam logic [Y_W-1:0]   LAST_Y = Y_W'(BLOCK_H - 1);
  localparam logic [X_W:0]     SCR_W  = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]     SCR_H  = (Y_W + 1)'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_e;

  state_e             state_q;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  logic [X_W-1:0]     head_x;
  logic [Y_W-1:0]     head_y;
  logic [COLOR_W-1:0] head_col;
  logic [1:0]         head_mode;

  logic [X_W-1:0]     wx_q, dx_q, dx_d;
  logic [Y_W-1:0]     wy_q, dy_q, dy_d;
  logic [COLOR_W-1:0] wcol_q;
  logic [1:0]         wmode_q;

  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;
  logic               last_pix, edge_pix, on_screen, pix_wr_d;
  logic [COLOR_W-1:0] pix_col_d;

  logic [X_W-1:0]     pix_x_q;
  logic [Y_W-1:0]     pix_y_q;
  logic [COLOR_W-1:0] pix_color_q;
  logic               pix_write_q, busy_q, done_q;

  assign req_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign fifo_count = count_q;
  assign {head_x, head_y, head_col, head_mode} = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {req_x, req_y, req_color, req_mode};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Offset of the pixel to be emitted at the coming edge: origin when leaving LOAD, else the row-major successor.
  always_comb begin
    last_pix = (dx_q == LAST_X) && (dy_q == LAST_Y);
    dx_d     = dx_q + 1'b1;
    dy_d     = dy_q;
    if (dx_q == LAST_X) begin
      dx_d = '0;
      dy_d = dy_q + 1'b1;
    end
    if (state_q == S_LOAD) begin
      dx_d = '0;
      dy_d = '0;
    end
    sum_x     = {1'b0, wx_q} + {1'b0, dx_d};
    sum_y     = {1'b0, wy_q} + {1'b0, dy_d};
    edge_pix  = (dx_d == '0) || (dx_d == LAST_X) || (dy_d == '0) || (dy_d == LAST_Y);
    on_screen = (sum_x < SCR_W) && (sum_y < SCR_H);
    pix_wr_d  = on_screen && !((wmode_q == 2'd1) && !edge_pix);
    pix_col_d = ((wmode_q == 2'd2) && edge_pix) ? BORDER_COLOR : wcol_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wx_q        <= '0;
      wy_q        <= '0;
      wcol_q      <= '0;
      wmode_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pix_write_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_LOAD;
            wx_q    <= head_x;
            wy_q    <= head_y;
            wcol_q  <= head_col;
            wmode_q <= head_mode;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD, S_DRAW: begin
          if ((state_q == S_DRAW) && last_pix) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_DRAW;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            pix_x_q     <= sum_x[X_W-1:0];
            pix_y_q     <= sum_y[Y_W-1:0];
            pix_color_q <= pix_col_d;
            pix_write_q <= pix_wr_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_write = pix_write_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/vga_rect_painter.md
# vga_rect_painter

Parametrised rectangle rasteriser that sits between sequencer/UI control logic and the `vga_adapter` framebuffer write port. It accepts queued draw requests (origin, colour, mode) over a valid/ready handshake, buffers them in a small FIFO, and rasterises each as a `BLOCK_W` x `BLOCK_H` rectangle, one pixel per clock. It is the generalised successor of the fixed 30x30 fill-only cell drawer. It adds configurable block size, colour depth, outline/bordered modes, screen-edge clipping, request queuing and a completion pulse.

## Interface
Parameters:
- `X_W`, 10, x coordinate width
- `Y_W`, 9, y coordinate width
- `COLOR_W`, 9, pixel colour width
- `BLOCK_W`, 30, rectangle width in pixels (1..2^X_W-1)
- `BLOCK_H`, 30, rectangle height in pixels (1..2^Y_W-1)
- `SCREEN_W`, 640, visible width; pixels with x >= SCREEN_W are clipped
- `SCREEN_H`, 480, visible height; pixels with y >= SCREEN_H are clipped
- `FIFO_DEPTH`, 4, request queue depth, power of two >= 2
- `BORDER_COLOR`, 9'h000, border colour used in mode 2

Ports:
- `CLOCK_50`  in  1  system clock
- `Reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  FIFO can accept; equals !full
- `req_x`  in  X_W  top-left x
- `req_y`  in  Y_W  top-left y
- `req_color`  in  COLOR_W  rectangle colour
- `req_mode`  in  2  0 = fill, 1 = outline only, 2 = fill + 1-px border in BORDER_COLOR, 3 = treated as 0
- `pix_x`  out  X_W  pixel x to adapter
- `pix_y`  out  Y_W  pixel y to adapter
- `pix_color`  out  COLOR_W  pixel colour to adapter
- `pix_write`  out  1  write strobe to adapter
- `busy`  out  1  high while a rectangle is in progress (LOAD, DRAW, DONE)
- `done`  out  1  one-cycle pulse after the last pixel of each rectangle
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  queued requests not yet popped

## Operation
- Push: on a rising edge with `req_valid && req_ready`, `{x, y, color, mode}` is written to the FIFO.
- Push and pop may occur in the same cycle; `fifo_count` is then unchanged.
- No push is possible while the FIFO is full.
- FSM states: IDLE, LOAD, DRAW, DONE.
- IDLE -> LOAD when the FIFO is non-empty. The head entry is popped and latched into working registers on that edge.
- LOAD -> DRAW unconditionally. `dx` and `dy` are cleared.
- DRAW: each cycle emits pixel (`x+dx`, `y+dy`) in row-major order. `dx` runs 0..BLOCK_W-1, then wraps to 0 and increments `dy`.
- DRAW -> DONE after the pixel at (BLOCK_W-1, BLOCK_H-1).
- DONE -> IDLE unconditionally. `done` is high for this one cycle.
- Arithmetic: `x+dx` is computed at X_W+1 bits and `y+dy` at Y_W+1 bits.
- Clipping: if the wide sum is >= SCREEN_W (or >= SCREEN_H for y), `pix_write` = 0 for that cycle. The cycle is still consumed, so draw time is always BLOCK_W*BLOCK_H cycles. Coordinates never wrap onto the screen.
- Edge pixel: dx = 0, dx = BLOCK_W-1, dy = 0, or dy = BLOCK_H-1.
- Mode 1: only edge pixels are written; for interior pixels `pix_write` = 0.
- Mode 2: edge pixels use BORDER_COLOR and interior pixels use the latched colour; all pixels are written.
- Modes 0 and 3: every pixel uses the latched colour.
- Outside DRAW, `pix_write` = 0. `pix_x`, `pix_y` and `pix_color` hold their last values.
- Reset: state IDLE, FIFO emptied. `req_ready` = 1 after reset, and all other outputs = 0.
- Reset mid-draw aborts the rectangle: no further writes and no `done` pulse. Reset dominates `req_valid` in the same cycle.

## Timing
- All outputs are registered except `req_ready`, which is decoded from the registered count.
- Latency, with a request accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - LOAD is entered at E1.
  - The first pixel is valid in the cycle after E2.
  - The last pixel is valid in the cycle after E2 + W*H - 1.
  - `done` is high in the cycle after E2 + W*H.
- Back-to-back requests: the next rectangle's first pixel follows its predecessor's last pixel by 3 cycles (DONE, IDLE, LOAD).
- `busy` rises at E1 and falls one cycle after `done`, unless another request is pending. In that case it stays low for exactly the IDLE cycle.

## Test plan
- Fill, default params, (100, 50), color 9'h1FF, mode 0:
  - 900 writes covering x 100..129, y 50..79, in row-major order.
  - First write 2 cycles after acceptance; exactly one `done` pulse.
- Outline at (0, 0), mode 1:
  - Exactly 116 writes, all on the perimeter.
  - Interior cycles have `pix_write` = 0; total DRAW time is 900 cycles.
- Clip at (620, 470), mode 0:
  - 200 writes, all with x <= 639 and y <= 479.
  - DRAW lasts 900 cycles; no wrapped coordinates appear.
- Queue full: hold `req_valid` high for 6 requests while the first is drawing.
  - `req_ready` drops when `fifo_count` = 4.
  - All accepted rectangles are drawn in order, with a 3-cycle gap between them.
- Mode 2 at (200, 100), color 9'h007:
  - 116 border pixels in BORDER_COLOR and 784 interior pixels in 9'h007.
- Reset asserted at pixel 450 of a draw with 2 requests queued:
  - No further writes and no `done` pulse.
  - `fifo_count` = 0 and `req_ready` = 1 on the cycle after reset.
